aurora_rx_stream_mux: RTL

Parametrised successor to the fixed three-source Aurora receive selector. It arbitrates NUM_CH upstream receive FIFOs, all in the Aurora log clock domain, onto a single DATA_W-bit stream feeding the XDMA video-in writer. It raises the XDMA start and memory-clear controls around each packet. Unlike the previous generation, it drains in-flight FIFO reads before clearing, supports configurable FIFO read latency and clear length, and keeps per-channel saturating pack counters and a beat counter.

---
 rtl/aurora_rx_stream_mux.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/aurora_rx_stream_mux.sv
// Priority-selects one of NUM_CH Aurora receive FIFOs per packet onto a single stream
// and frames each packet with the XDMA video-in start and memory-clear controls.
module aurora_rx_stream_mux #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 64,
  parameter int RD_LAT  = 1,
  parameter int CLR_CYC = 128,
  parameter int CNT_W   = 32,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      aurora_log_clk,
  input  logic                      aurora_rst,
  input  logic [NUM_CH-1:0]         rx_start_i,
  input  logic [NUM_CH-1:0]         rx_abort_i,
  input  logic [NUM_CH-1:0]         fifo_almost_empty_i,
  input  logic [NUM_CH*DATA_W-1:0]  fifo_dout_i,
  output logic [NUM_CH-1:0]         fifo_rd_en_o,
  output logic                      aurora_rxen_o,
  output logic [DATA_W-1:0]         aurora_rxdata_o,
  output logic                      xdma_vin_start_o,
  output logic                      xdma_vin_mem_clear_o,
  output logic [CH_W-1:0]           active_ch_o,
  output logic [NUM_CH*CNT_W-1:0]   pack_cnt_o,
  output logic [CNT_W-1:0]          beat_cnt_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_CLEAR = 2'd3;

  localparam logic [7:0]       DRAIN_LAST = 8'(RD_LAT + 1);
  localparam logic [7:0]       CLEAR_LAST = 8'(CLR_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] vec);
    logic [CH_W-1:0] idx;
    idx = {CH_W{1'b0}};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = CH_W'(i);
      end
    end
    return idx;
  endfunction

  logic [1:0]               state_r;
  logic [1:0]               state_nxt_s;
  logic [7:0]               phase_cnt_r;
  logic [NUM_CH-1:0]        start_d_r;
  logic [NUM_CH-1:0]        rise_s;
  logic                     restart_s;
  logic                     launch_s;
  logic                     read_ok_s;
  logic                     keep_beat_s;
  logic [CH_W-1:0]          ch_r;
  logic [CH_W-1:0]          pick_s;
  logic                     ch_start_s;
  logic                     ch_ae_s;
  logic                     ch_abort_s;
  logic                     ch_rd_s;
  logic [DATA_W-1:0]        ch_dout_s;
  logic [NUM_CH-1:0]        rd_en_r;
  logic [NUM_CH-1:0]        rd_en_nxt_s;
  logic [RD_LAT-1:0]        vld_pipe_r;
  logic                     rxen_r;
  logic [DATA_W-1:0]        rxdata_r;
  logic                     vin_start_r;
  logic                     mem_clear_r;
  logic [NUM_CH*CNT_W-1:0]  pack_cnt_r;
  logic [CNT_W-1:0]         beat_cnt_r;

  // AND-OR mux of the latched channel's handshake bits and FIFO data.
  always_comb begin
    ch_start_s = 1'b0;
    ch_ae_s    = 1'b0;
    ch_abort_s = 1'b0;
    ch_rd_s    = 1'b0;
    ch_dout_s  = {DATA_W{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      ch_start_s = ch_start_s | (rx_start_i[k] & (ch_r == CH_W'(k)));
      ch_ae_s    = ch_ae_s | (fifo_almost_empty_i[k] & (ch_r == CH_W'(k)));
      ch_abort_s = ch_abort_s | (rx_abort_i[k] & (ch_r == CH_W'(k)));
      ch_rd_s    = ch_rd_s | (rd_en_r[k] & (ch_r == CH_W'(k)));
      ch_dout_s  = ch_dout_s | (fifo_dout_i[k*DATA_W +: DATA_W] & {DATA_W{ch_r == CH_W'(k)}});
    end
  end

  // Next-state and read-enable decode; a fresh rise outside IDLE out-ranks every transition.
  always_comb begin
    rise_s      = rx_start_i & ~start_d_r;
    restart_s   = (state_r != ST_IDLE) && (|rise_s);
    launch_s    = (state_r == ST_IDLE) && (|rx_start_i);
    pick_s      = lowest_set(rx_start_i);
    state_nxt_s = state_r;
    if (restart_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:  state_nxt_s = launch_s ? ST_RUN : ST_IDLE;
        ST_RUN:   state_nxt_s = (!ch_start_s && ch_ae_s) ? ST_DRAIN : ST_RUN;
        ST_DRAIN: state_nxt_s = (phase_cnt_r == DRAIN_LAST) ? ST_CLEAR : ST_DRAIN;
        ST_CLEAR: state_nxt_s = (phase_cnt_r == CLEAR_LAST) ? ST_IDLE : ST_CLEAR;
        default:  state_nxt_s = ST_IDLE;
      endcase
    end
    read_ok_s   = (state_r == ST_RUN) && !restart_s && !ch_ae_s && !ch_abort_s;
    rd_en_nxt_s = {NUM_CH{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      rd_en_nxt_s[k] = read_ok_s && (ch_r == CH_W'(k));
    end
    // Beats only leave in RUN/DRAIN; a restart drops whatever is still in flight.
    keep_beat_s = (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN);
  end

  // Control state, phase timer, channel latch and framing outputs.
  always_ff @(posedge aurora_log_clk) begin
    if (aurora_rst) begin
      state_r     <= ST_IDLE;
      phase_cnt_r <= 8'd0;
      start_d_r   <= {NUM_CH{1'b0}};
      ch_r        <= {CH_W{1'b0}};
      rd_en_r     <= {NUM_CH{1'b0}};
      vin_start_r <= 1'b0;
      mem_clear_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      phase_cnt_r <= (state_nxt_s != state_r) ? 8'd0 : phase_cnt_r + 8'd1;
      start_d_r   <= rx_start_i;
      rd_en_r     <= rd_en_nxt_s;
      vin_start_r <= (state_nxt_s != ST_IDLE);
      mem_clear_r <= (state_nxt_s == ST_CLEAR);
      if (launch_s) begin
        ch_r <= pick_s;
      end
    end
  end

  // Read-valid shift pipe matching the FIFO read latency.
  always_ff @(posedge aurora_log_clk) begin
    if (aurora_rst || restart_s) begin
      vld_pipe_r <= {RD_LAT{1'b0}};
    end else begin
      vld_pipe_r[0] <= ch_rd_s;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe_r[i] <= vld_pipe_r[i-1];
      end
    end
  end

  // Output beat register; data is zeroed whenever no beat is presented.
  always_ff @(posedge aurora_log_clk) begin
    if (aurora_rst) begin
      rxen_r   <= 1'b0;
      rxdata_r <= {DATA_W{1'b0}};
    end else if (vld_pipe_r[RD_LAT-1] && keep_beat_s) begin
      rxen_r   <= 1'b1;
      rxdata_r <= ch_dout_s;
    end else begin
      rxen_r   <= 1'b0;
      rxdata_r <= {DATA_W{1'b0}};
    end
  end

  // Saturating per-channel pack counters and per-pack beat counter.
  always_ff @(posedge aurora_log_clk) begin
    if (aurora_rst) begin
      pack_cnt_r <= {(NUM_CH*CNT_W){1'b0}};
      beat_cnt_r <= {CNT_W{1'b0}};
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (launch_s && (pick_s == CH_W'(k)) && (pack_cnt_r[k*CNT_W +: CNT_W] != CNT_MAX)) begin
          pack_cnt_r[k*CNT_W +: CNT_W] <= pack_cnt_r[k*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
      if (launch_s) begin
        beat_cnt_r <= {CNT_W{1'b0}};
      end else if (rxen_r && (beat_cnt_r != CNT_MAX)) begin
        beat_cnt_r <= beat_cnt_r + CNT_W'(1);
      end
    end
  end

  assign fifo_rd_en_o         = rd_en_r;
  assign aurora_rxen_o        = rxen_r;
  assign aurora_rxdata_o      = rxdata_r;
  assign xdma_vin_start_o     = vin_start_r;
  assign xdma_vin_mem_clear_o = mem_clear_r;
  assign active_ch_o          = ch_r;
  assign pack_cnt_o           = pack_cnt_r;
  assign beat_cnt_o           = beat_cnt_r;

endmodule
